// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and constants for the byte-enabled register file
package reg_file_pkg;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_BYTES  = DEF_DATA_W / 8;
  localparam int unsigned REG0       = 0;
endpackage

// File: rtl/reg_word.sv
// reg_word: one DATA_W-bit register with async active-low clear and per-byte load enables
//   clk     rising-edge clock
//   clear_n asynchronous active-low clear
//   be_i    byte-lane load enables
//   d_i     load data
//   q_o     stored word
module reg_word
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   q_o
);
  logic [DATA_W-1:0] q_q, q_d;
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_lane
    assign q_d[8*b+:8] = be_i[b] ? d_i[8*b+:8] : q_q[8*b+:8];
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/reg_file_be.sv
// reg_file_be: 2-read/1-write register file with byte enables, optional zero reg and bypass
//   clk       rising-edge clock
//   clear_n   asynchronous active-low reset
//   R_addr_A  read address A, R_addr_B read address B
//   W_addr    write address, W_data write data, Write strobe, W_be byte enables
//   rdata_A   read data A, rdata_B read data B (combinational)
module reg_file_be
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic [ADDR_W-1:0]   R_addr_A,
  input  logic [ADDR_W-1:0]   R_addr_B,
  input  logic [ADDR_W-1:0]   W_addr,
  input  logic [DATA_W-1:0]   W_data,
  input  logic                Write,
  input  logic [DATA_W/8-1:0] W_be,
  output logic [DATA_W-1:0]   rdata_A,
  output logic [DATA_W-1:0]   rdata_B
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SLOTS = 2 ** ADDR_W;
  if (DATA_W % 8 != 0 || DATA_W < 8 || NUM_REGS < 2 || NUM_REGS > SLOTS) begin : g_bad_cfg
    $error("reg_file_be: illegal DATA_W/NUM_REGS/ADDR_W combination");
  end
  // The array spans the whole address space; unimplemented slots are tied to 0,
  // so out-of-range reads return 0 with no extra decode.
  logic [DATA_W-1:0] regs [SLOTS];
  logic [DATA_W-1:0] mask, merged;
  logic              we;
  assign we = clear_n && Write && |W_be && (32'(W_addr) < NUM_REGS)
              && !(ZERO_REG != 0 && W_addr == ADDR_W'(REG0));
  for (genvar i = 0; i < SLOTS; i++) begin : g_reg
    if (i >= NUM_REGS || (ZERO_REG != 0 && i == REG0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_word
      reg_word #(.DATA_W(DATA_W)) u_word (
        .clk    (clk),
        .clear_n(clear_n),
        .be_i   (W_be & {BYTES{we && W_addr == ADDR_W'(i)}}),
        .d_i    (W_data),
        .q_o    (regs[i])
      );
    end
  end
  for (genvar b = 0; b < BYTES; b++) begin : g_mask
    assign mask[8*b+:8] = {8{W_be[b]}};
  end
  // Forwarded value is what the target register will hold after this edge.
  assign merged  = (W_data & mask) | (regs[W_addr] & ~mask);
  assign rdata_A = !clear_n ? '0 : (BYPASS != 0 && we && R_addr_A == W_addr) ? merged : regs[R_addr_A];
  assign rdata_B = !clear_n ? '0 : (BYPASS != 0 && we && R_addr_B == W_addr) ? merged : regs[R_addr_B];
endmodule

// File: tb/tb_reg_file_be.sv
// tb_reg_file_be: randomized scoreboard bench for two reg_file_be configurations
module tb_reg_file_be;
  typedef struct {
    string       nm;
    int          port;
    logic [31:0] exp;
  } exp_t;
  logic        clk, clear_n, Write;
  logic [4:0]  R_addr_A, R_addr_B, W_addr;
  logic [31:0] W_data;
  logic [3:0]  W_be;
  logic [31:0] rdata_A1, rdata_B1, rdata_A2, rdata_B2;
  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  event        ev;
  reg_file_be u_dut1 (
    .clk(clk), .clear_n(clear_n), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .W_addr(W_addr), .W_data(W_data), .Write(Write), .W_be(W_be),
    .rdata_A(rdata_A1), .rdata_B(rdata_B1)
  );
  reg_file_be #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) u_dut2 (
    .clk(clk), .clear_n(clear_n), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .W_addr(W_addr), .W_data(W_data), .Write(Write), .W_be(W_be),
    .rdata_A(rdata_A2), .rdata_B(rdata_B2)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b+:8] = d[8*b+:8];
    return o;
  endfunction
  function automatic bit commits(int n, bit z);
    return clear_n && Write && W_be != 0 && int'(W_addr) < n && !(z && W_addr == 0);
  endfunction
  function automatic logic [31:0] exp_rd(int which, logic [4:0] a);
    int n = which == 0 ? 32 : 24;
    bit z = which == 0;
    bit byp = which == 0;
    logic [31:0] old = which == 0 ? m1[a] : m2[a];
    if (!clear_n) return 0;
    if (int'(a) >= n || (z && a == 0)) return 0;
    if (byp && commits(n, z) && a == W_addr) return merge(old, W_data, W_be);
    return old;
  endfunction
  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      m1[i] = 0;
      m2[i] = 0;
    end
  endtask
  task automatic commit();
    if (commits(32, 1)) m1[W_addr] = merge(m1[W_addr], W_data, W_be);
    if (commits(24, 0)) m2[W_addr] = merge(m2[W_addr], W_data, W_be);
  endtask
  task automatic push_exp(string nm);
    sb.push_back('{{nm, "_A1"}, 0, exp_rd(0, R_addr_A)});
    sb.push_back('{{nm, "_B1"}, 1, exp_rd(0, R_addr_B)});
    sb.push_back('{{nm, "_A2"}, 2, exp_rd(1, R_addr_A)});
    sb.push_back('{{nm, "_B2"}, 3, exp_rd(1, R_addr_B)});
    -> ev;
  endtask
  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                      input logic [31:0] wd, input logic w, input logic [3:0] be,
                      input logic rn, input string nm);
    @(negedge clk);
    R_addr_A = ra;
    R_addr_B = rb;
    W_addr   = wa;
    W_data   = wd;
    Write    = w;
    W_be     = be;
    clear_n  = rn;
    if (!rn) clear_models();
    push_exp(nm);
    @(posedge clk);
    commit();
  endtask
  initial begin
    logic [31:0] act;
    exp_t        e;
    forever begin
      @(ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = e.port == 0 ? rdata_A1 : e.port == 1 ? rdata_B1 : e.port == 2 ? rdata_A2 : rdata_B2;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s got %08h expected %08h at %0t", e.nm, act, e.exp, $time);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    clear_n = 0;
    Write = 0;
    W_be = 0;
    W_data = 0;
    W_addr = 0;
    R_addr_A = 0;
    R_addr_B = 0;
    clear_models();
    step(5, 6, 5, 32'hDEADBEEF, 1, 4'hF, 0, "rst_write");
    step(5, 5, 0, 0, 0, 0, 1, "rst_release");
    step(1, 2, 5, 32'hDEADBEEF, 1, 4'hF, 1, "wr5");
    step(5, 5, 0, 0, 0, 0, 1, "rd5");
    @(negedge clk);
    #2;
    clear_n = 0;
    clear_models();
    push_exp("async_clr");
    @(posedge clk);
    step(5, 5, 5, 32'h12345678, 1, 4'hF, 0, "wr_in_rst");
    step(5, 5, 0, 0, 0, 0, 1, "after_rel");
    step(0, 0, 3, 32'h11223344, 1, 4'hF, 1, "ld3");
    step(3, 3, 3, 32'hAABBCCDD, 1, 4'b0101, 1, "be0101");
    step(3, 3, 3, 32'hFFFFFFFF, 1, 4'b0000, 1, "be0");
    step(3, 3, 0, 0, 0, 0, 1, "rd3");
    step(0, 0, 0, 32'hFFFFFFFF, 1, 4'hF, 1, "wr0");
    step(0, 0, 0, 0, 0, 0, 1, "rd0");
    step(7, 7, 7, 32'h12345678, 1, 4'b1100, 1, "byp7");
    step(7, 7, 0, 0, 0, 0, 1, "hold7");
    step(30, 14, 30, 32'hCAFEF00D, 1, 4'hF, 1, "oor30");
    step(30, 14, 0, 0, 0, 0, 1, "rd30");
    step(23, 24, 23, 32'h0BADCAFE, 1, 4'hF, 1, "edge23");
    step(23, 24, 24, 32'h5A5A5A5A, 1, 4'hF, 1, "edge24");
    for (int i = 0; i < 10000; i++)
      step(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
           4'($urandom), 1'($urandom_range(0, 299) != 0), "rand");
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
